// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - multi-channel fixed-point partial-sum accumulator with overflow/saturation
module psum_accumulator #(
    parameter int I_WIDTH = 8,
    parameter int F_WIDTH = 8,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [N_CH*(I_WIDTH+F_WIDTH)-1:0] data_i,
    input  logic [CNT_W-1:0]                 len_i,
    input  logic                             add_en_i,
    input  logic                             sat_en_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [N_CH*(I_WIDTH+F_WIDTH)-1:0] sum_o,
    output logic [N_CH-1:0]                  ovf_o
);

    localparam int W = I_WIDTH + F_WIDTH;
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    len_q;
    logic [N_CH*W-1:0]   acc_q;
    logic [N_CH*W-1:0]   acc_d;
    logic [N_CH-1:0]     ovf_q;
    logic [N_CH-1:0]     ovf_d;
    logic                accept;
    logic                last_beat;

    logic [W:0]          lane_sum;
    logic [W-1:0]        lane_acc;
    logic [W-1:0]        lane_op;
    logic [W-1:0]        lane_f;
    logic                lane_ovf;

    // Input is only taken while collecting a group; a pending result blocks new beats.
    assign ready_o = (state == ST_ACC);
    assign accept  = valid_i && ready_o;

    // The first beat decides group length from len_i directly (len_q is not loaded yet).
    assign last_beat = (cnt == '0) ? (len_i <= CNT_W'(1))
                                   : (({1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, len_q});

    // Per-lane next accumulator and sticky overflow for the beat on data_i.
    always_comb begin
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        lane_sum = '0;
        lane_acc = '0;
        lane_op  = '0;
        lane_f   = '0;
        lane_ovf = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            lane_acc = acc_q[k*W +: W];
            lane_op  = data_i[k*W +: W];
            lane_sum = {lane_acc[W-1], lane_acc} + {lane_op[W-1], lane_op};
            lane_ovf = (lane_sum[W] != lane_sum[W-1]);
            if (lane_ovf && sat_en_i) begin
                lane_f = lane_sum[W] ? SAT_MIN : SAT_MAX;
            end else begin
                lane_f = lane_sum[W-1:0];
            end
            if (cnt == '0) begin
                acc_d[k*W +: W] = lane_op;
                ovf_d[k]        = 1'b0;
            end else if (add_en_i) begin
                acc_d[k*W +: W] = lane_f;
                ovf_d[k]        = ovf_q[k] | lane_ovf;
            end else begin
                acc_d[k*W +: W] = lane_op;
                ovf_d[k]        = ovf_q[k];
            end
        end
    end

    // Control FSM: collect beats in ACC, present the registered result in OUT until taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_ACC;
            cnt     <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= '0;
            sum_o   <= '0;
            ovf_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        if (cnt == '0) begin
                            len_q <= (len_i == '0) ? CNT_W'(1) : len_i;
                        end
                        if (last_beat) begin
                            cnt     <= '0;
                            sum_o   <= acc_d;
                            ovf_o   <= ovf_d;
                            valid_o <= 1'b1;
                            state   <= ST_OUT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - self-checking bench for psum_accumulator (2 lanes, Q8.8)
module tb_psum_accumulator;

    localparam int W    = 16;
    localparam int N_CH = 2;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              valid_i;
    logic              ready_o;
    logic [N_CH*W-1:0] data_i;
    logic [7:0]        len_i;
    logic              add_en_i;
    logic              sat_en_i;
    logic              valid_o;
    logic              ready_i;
    logic [N_CH*W-1:0] sum_o;
    logic [N_CH-1:0]   ovf_o;

    int checks = 0;
    int errors = 0;

    psum_accumulator #(.I_WIDTH(8), .F_WIDTH(8), .N_CH(N_CH), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .len_i(len_i), .add_en_i(add_en_i), .sat_en_i(sat_en_i),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0][15:0] d0;
        logic [3:0][15:0] d1;
        logic [3:0]       add;
        logic             sat;
        logic [15:0]      e0;
        logic [15:0]      e1;
        logic [1:0]       eo;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] len, input logic [63:0] d0, input logic [63:0] d1,
                                input logic [3:0] add, input logic sat,
                                input logic [15:0] e0, input logic [15:0] e1, input logic [1:0] eo);
        vec_t v;
        v.len = len; v.d0 = d0; v.d1 = d1; v.add = add; v.sat = sat;
        v.e0 = e0; v.e1 = e1; v.eo = eo;
        return v;
    endfunction

    function automatic int sx(input logic [15:0] x);
        int r;
        r = {{16{x[15]}}, x};
        return r;
    endfunction

    // Reference: integer arithmetic with explicit range test, clamp or modular wrap.
    function automatic void model(input vec_t v, output logic [15:0] s0, output logic [15:0] s1,
                                  output logic [1:0] ov);
        int nb;
        int acc;
        int s;
        nb = (v.len == 0) ? 1 : int'(v.len);
        for (int lane = 0; lane < 2; lane++) begin
            ov[lane] = 1'b0;
            acc = sx(lane == 0 ? v.d0[0] : v.d1[0]);
            for (int i = 1; i < nb; i++) begin
                if (v.add[i]) begin
                    s = acc + sx(lane == 0 ? v.d0[i] : v.d1[i]);
                    if (s > 32767 || s < -32768) begin
                        ov[lane] = 1'b1;
                        if (v.sat) s = (s > 0) ? 32767 : -32768;
                        else       s = (s > 0) ? s - 65536 : s + 65536;
                    end
                    acc = s;
                end else begin
                    acc = sx(lane == 0 ? v.d0[i] : v.d1[i]);
                end
            end
            if (lane == 0) s0 = acc[15:0];
            else           s1 = acc[15:0];
        end
    endfunction

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [7:0] len,
                        input logic add, input logic sat);
        int n = 0;
        while (!ready_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_beat", ready_o, 1);
        valid_i = 1'b1; data_i = {b, a}; len_i = len; add_en_i = add; sat_en_i = sat;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic release_out();
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("released_valid", valid_o, 0);
        chk("released_ready", ready_o, 1);
    endtask

    task automatic run_group(input vec_t v, input int hold);
        int nb;
        nb = (v.len == 0) ? 1 : int'(v.len);
        ready_i = (hold == 0);
        for (int i = 0; i < nb; i++) begin
            if (i > 0) chk("mid_group_valid", valid_o, 0);
            beat(v.d0[i], v.d1[i], v.len, v.add[i], v.sat);
        end
        chk("latency_valid", valid_o, 1);
        chk("out_ready_low", ready_o, 0);
        chk("sum_lane0", sum_o[15:0], v.e0);
        chk("sum_lane1", sum_o[31:16], v.e1);
        chk("ovf", ovf_o, v.eo);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            chk("held_valid", valid_o, 1);
            chk("held_sum", sum_o, {v.e1, v.e0});
        end
        release_out();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        v;
        logic [15:0] m0, m1;
        logic [1:0]  mo;
        logic [31:0] held;

        tbl[0] = mk(3, {16'h0, 16'h0080, 16'h0200, 16'h0100}, 64'h0, 4'b1111, 0, 16'h0380, 16'h0, 2'b00);
        tbl[1] = mk(2, 64'h0, {16'h0, 16'h0, 16'h2000, 16'h7000}, 4'b1111, 1, 16'h0, 16'h7FFF, 2'b10);
        tbl[2] = mk(2, 64'h0, {16'h0, 16'h0, 16'h2000, 16'h7000}, 4'b1111, 0, 16'h0, 16'h9000, 2'b10);
        tbl[3] = mk(2, 64'h0, {16'h0, 16'h0, 16'h9000, 16'h9000}, 4'b1111, 1, 16'h0, 16'h8000, 2'b10);
        tbl[4] = mk(4, {16'h0001, 16'h0010, 16'h2000, 16'h7000}, 64'h0, 4'b1011, 0, 16'h0011, 16'h0, 2'b01);
        tbl[5] = mk(0, {48'h0, 16'h1234}, {48'h0, 16'hFEDC}, 4'b1111, 0, 16'h1234, 16'hFEDC, 2'b00);
        tbl[6] = mk(1, {48'h0, 16'h8000}, {48'h0, 16'h7FFF}, 4'b1111, 1, 16'h8000, 16'h7FFF, 2'b00);
        tbl[7] = mk(2, {32'h0, 16'hFFFF, 16'h8000}, {32'h0, 16'h8000, 16'h7FFF}, 4'b1111, 0, 16'h7FFF, 16'hFFFF, 2'b01);
        tbl[8] = mk(2, {32'h0, 16'hFFFF, 16'h8000}, {32'h0, 16'h8000, 16'h7FFF}, 4'b1111, 1, 16'h8000, 16'hFFFF, 2'b01);
        tbl[9] = mk(3, {16'h0, 16'hFFFF, 16'h0001, 16'hFFFF}, {16'h0, 16'h8000, 16'h0001, 16'h7FFF}, 4'b1111, 1, 16'hFFFF, 16'hFFFF, 2'b10);

        rst_i = 1'b1; valid_i = 1'b0; data_i = '0; len_i = '0;
        add_en_i = 1'b1; sat_en_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        chk("reset_ready", ready_o, 1);
        chk("reset_valid", valid_o, 0);
        chk("reset_sum", sum_o, 0);
        chk("reset_ovf", ovf_o, 0);

        for (int i = 0; i < 10; i++) run_group(tbl[i], 0);

        // len_i change mid-group is ignored: group of 3 even though later beats say 5
        ready_i = 1'b1;
        beat(16'h0001, 16'h0, 8'd3, 1'b1, 1'b0);
        beat(16'h0002, 16'h0, 8'd5, 1'b1, 1'b0);
        chk("len_change_not_done", valid_o, 0);
        beat(16'h0003, 16'h0, 8'd5, 1'b1, 1'b0);
        chk("len_change_valid", valid_o, 1);
        chk("len_change_sum", sum_o[15:0], 16'h0006);
        release_out();

        // Backpressure: pending result with a new beat waiting on valid_i
        ready_i = 1'b0;
        beat(16'h0100, 16'h0, 8'd2, 1'b1, 1'b0);
        beat(16'h0100, 16'h0, 8'd2, 1'b1, 1'b0);
        held = sum_o;
        chk("bp_sum", held, 32'h0000_0200);
        valid_i = 1'b1; data_i = {16'h0007, 16'h0042}; len_i = 8'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_ready_low", ready_o, 0);
            chk("bp_valid_high", valid_o, 1);
            chk("bp_sum_stable", sum_o, held);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", valid_o, 0);
        chk("bp_release_ready", ready_o, 1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("bp_held_beat_valid", valid_o, 1);
        chk("bp_held_beat_sum", sum_o, 32'h0007_0042);
        release_out();

        // Reset mid-group
        beat(16'h0100, 16'h0100, 8'd4, 1'b1, 1'b0);
        beat(16'h0100, 16'h0100, 8'd4, 1'b1, 1'b0);
        rst_i = 1'b1; @(posedge clk); #1; rst_i = 1'b0;
        chk("rst_mid_valid", valid_o, 0);
        chk("rst_mid_sum", sum_o, 0);
        chk("rst_mid_ready", ready_o, 1);

        // Reset during OUT of an overflowing group
        ready_i = 1'b0;
        beat(16'h7000, 16'h0, 8'd2, 1'b1, 1'b0);
        beat(16'h2000, 16'h0, 8'd2, 1'b1, 1'b0);
        chk("pre_rst_out_ovf", ovf_o, 2'b01);
        rst_i = 1'b1; @(posedge clk); #1; rst_i = 1'b0;
        chk("rst_out_valid", valid_o, 0);
        chk("rst_out_sum", sum_o, 0);
        chk("rst_out_ovf", ovf_o, 0);
        chk("rst_out_ready", ready_o, 1);
        run_group(mk(2, {32'h0, 16'h0001, 16'h0001}, 64'h0, 4'b1111, 0, 16'h0002, 16'h0, 2'b00), 0);

        // Randomized groups against the reference model
        for (int g = 0; g < 60; g++) begin
            v.len = 8'($urandom_range(0, 4));
            for (int i = 0; i < 4; i++) begin
                v.d0[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                v.d1[i] = 16'($urandom);
            end
            v.add = 4'($urandom);
            v.sat = 1'($urandom);
            model(v, m0, m1, mo);
            v.e0 = m0; v.e1 = m1; v.eo = mo;
            run_group(v, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
